obi_to_axil_bridge: RTL and testbench
=====================================

Name: obi_to_axil_bridge

Overview:
- Converts the cv32e40p data-side OBI master interface into AXI4-Lite master channels.
- Drives the data port of the dual-port instruction/data RAM, or the SoC data interconnect placed in front of it.
- Exactly one transaction in flight on AXI at a time; AXI ordering matches OBI order.
- Write responses are returned to the core as OBI rvalid pulses, as the core requires.

Parameters:
ADDR_W, 32, address width on both sides
DATA_W, 32, data width; strobe width is DATA_W/8
ALIGN_ADDR, 1, 1 = force addr[1:0] to 2'b00 on AXI address outputs; 0 = pass addr through unchanged

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
obi_req_i  in  1  OBI request
obi_gnt_o  out  1  OBI grant, combinational
obi_addr_i  in  ADDR_W  byte address
obi_we_i  in  1  1 = write
obi_be_i  in  4  byte enables
obi_wdata_i  in  DATA_W  write data
obi_rvalid_o  out  1  response valid, one-cycle pulse
obi_rdata_o  out  DATA_W  read data, valid with rvalid
obi_err_o  out  1  error flag, valid with rvalid
m_awaddr  out  ADDR_W  AXI write address
m_awvalid  out  1  AXI AW valid
m_awready  in  1  AXI AW ready
m_wdata  out  DATA_W  AXI write data
m_wstrb  out  4  AXI write strobe
m_wvalid  out  1  AXI W valid
m_wready  in  1  AXI W ready
m_bresp  in  2  AXI B response; tie 2'b00 for slaves without bresp
m_bvalid  in  1  AXI B valid
m_bready  out  1  AXI B ready
m_araddr  out  ADDR_W  AXI read address
m_arvalid  out  1  AXI AR valid
m_arready  in  1  AXI AR ready
m_rdata  in  DATA_W  AXI read data
m_rresp  in  2  AXI R response; tie 2'b00 for slaves without rresp
m_rvalid  in  1  AXI R valid
m_rready  out  1  AXI R ready

Behaviour:
- Reset: FSM goes to IDLE. Cleared to 0: every valid and ready output, obi_rvalid_o, obi_err_o, obi_rdata_o, and all address/data/strobe registers.
- obi_gnt_o = obi_req_i && state==IDLE. On grant, addr, we, be and wdata are captured into registers.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: on grant with we=1, go to WR and set awvalid=wvalid=1 on the next edge. With we=0, go to RD_ADDR and set arvalid=1.
- WR: awvalid and wvalid are tracked independently.
  - Each valid drops the cycle after its own handshake.
  - Order of AW/W acceptance is free, and simultaneous acceptance is allowed.
  - Once both channels are done, go to WR_RESP with bready=1.
- WR_RESP: on bvalid&&bready:
  - bready drops, state returns to IDLE.
  - Next cycle: obi_rvalid_o=1, obi_err_o=bresp[1], obi_rdata_o=0.
- RD_ADDR: arvalid stays held until arready. On handshake, arvalid drops and state goes to RD_DATA with rready=1.
- RD_DATA: on rvalid&&rready:
  - rdata and rresp[1] are registered, rready drops, state returns to IDLE.
  - Next cycle: obi_rvalid_o=1 with the registered data and error.
- Address/data stability: AXI address, data and strobe outputs hold stable from valid assertion until handshake (AXI rule). Valids are never withdrawn before handshake.
- Minimum latency, measured from the grant cycle:
  - Write against an always-ready zero-wait slave (bvalid one cycle after AW/W): obi_rvalid_o at grant+3.
  - Read against a slave with registered rvalid: obi_rvalid_o at grant+3.
- Back-to-back: a new grant is possible in the same cycle obi_rvalid_o pulses for the previous access, because the FSM is already in IDLE. obi_rvalid_o is never high for 2 consecutive cycles from one transaction.
- Stall: obi_req_i held while not in IDLE gets no grant. OBI inputs are ignored when not granted.
- Unsolicited input: m_bvalid/m_rvalid outside WR_RESP/RD_DATA is ignored, since ready is 0.
- Error decoding: resp 2'b10 (SLVERR) or 2'b11 (DECERR) sets obi_err_o. OKAY and EXOKAY do not.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). No response is issued for the aborted access. The system-wide reset covers the slave.

Decomposition:
- Shared package soc_bus_pkg:
  - AXI resp encodings: RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR.
  - bridge_state_t enum.
  - Default ADDR_W/DATA_W constants.
- Single module; no sub-module is warranted.

Test Plan:
1. Write, zero-wait slave: addr=0x0000_0104, be=4'b0011, wdata=0xDEAD_BEEF → awaddr=0x104, wstrb=0x3, wdata=0xDEADBEEF in one cycle; obi_rvalid_o at grant+3, err=0.
2. Read after write: read 0x104 → araddr=0x104; obi_rdata_o=0x0000_BEEF (prior word 0) with rvalid, err=0.
3. AW/W skew: awready held low 3 cycles, wready immediate → wvalid drops after 1 cycle; awvalid held with stable awaddr until awready; exactly one bready handshake and one obi_rvalid_o pulse.
4. Error: rresp=2'b10 on a read → obi_rvalid_o=1, obi_err_o=1; next read with rresp=2'b00 → err=0.
5. Back-to-back: req held high for 4 alternating write/read accesses → grant only in IDLE; 4 rvalid pulses in order; no overlapping AXI valids.
6. Reset mid-read: assert rst_n low while in RD_DATA → all outputs 0 immediately; after release, FSM in IDLE; no obi_rvalid_o for the aborted read.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared bus definitions for the SoC data path: AXI response codes,
// bridge FSM states and default bus widths.
package soc_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } bridge_state_t;

  // SLVERR and DECERR are reported to the core; OKAY and EXOKAY are not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/obi_to_axil_bridge_if.sv
// OBI data port plus AXI4-Lite master channels seen by the bridge.
interface obi_to_axil_bridge_if
  import soc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic                  obi_req_i;
  logic                  obi_gnt_o;
  logic [ADDR_W-1:0]     obi_addr_i;
  logic                  obi_we_i;
  logic [DATA_W/8-1:0]   obi_be_i;
  logic [DATA_W-1:0]     obi_wdata_i;
  logic                  obi_rvalid_o;
  logic [DATA_W-1:0]     obi_rdata_o;
  logic                  obi_err_o;

  logic [ADDR_W-1:0]     m_awaddr;
  logic                  m_awvalid;
  logic                  m_awready;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_wstrb;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [1:0]            m_bresp;
  logic                  m_bvalid;
  logic                  m_bready;
  logic [ADDR_W-1:0]     m_araddr;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [DATA_W-1:0]     m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rvalid;
  logic                  m_rready;

  // Bridge view: OBI slave towards the core, AXI master towards memory.
  modport master (
    input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
    output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    input  m_arready, m_rdata, m_rresp, m_rvalid
  );

  // Environment view: core plus AXI slave.
  modport slave (
    output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
    input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid,
    output m_arready, m_rdata, m_rresp, m_rvalid
  );

endinterface

// File: rtl/obi_to_axil_bridge.sv
// cv32e40p data-side OBI to AXI4-Lite bridge; one AXI transaction in flight,
// write completions returned to the core as OBI rvalid pulses.
module obi_to_axil_bridge
  import soc_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter bit          ALIGN_ADDR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  obi_to_axil_bridge_if.master bus
);

  localparam int unsigned STRB_W = DATA_W / 8;

  bridge_state_t       state_r, state_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [STRB_W-1:0]   be_r, be_nxt_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nxt_s;
  logic                awvalid_r, awvalid_nxt_s;
  logic                wvalid_r, wvalid_nxt_s;
  logic                bready_r, bready_nxt_s;
  logic                arvalid_r, arvalid_nxt_s;
  logic                rready_r, rready_nxt_s;
  logic                rvalid_r, rvalid_nxt_s;
  logic [DATA_W-1:0]   rdata_r, rdata_nxt_s;
  logic                err_r, err_nxt_s;
  logic                gnt_s;
  logic [ADDR_W-1:0]   axi_addr_s;

  assign gnt_s      = bus.obi_req_i && (state_r == IDLE);
  assign axi_addr_s = ALIGN_ADDR ? {addr_r[ADDR_W-1:2], 2'b00} : addr_r;

  assign bus.obi_gnt_o    = gnt_s;
  assign bus.obi_rvalid_o = rvalid_r;
  assign bus.obi_rdata_o  = rdata_r;
  assign bus.obi_err_o    = err_r;
  assign bus.m_awaddr     = axi_addr_s;
  assign bus.m_awvalid    = awvalid_r;
  assign bus.m_wdata      = wdata_r;
  assign bus.m_wstrb      = be_r;
  assign bus.m_wvalid     = wvalid_r;
  assign bus.m_bready     = bready_r;
  assign bus.m_araddr     = axi_addr_s;
  assign bus.m_arvalid    = arvalid_r;
  assign bus.m_rready     = rready_r;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_nxt_s   = state_r;
    addr_nxt_s    = addr_r;
    be_nxt_s      = be_r;
    wdata_nxt_s   = wdata_r;
    awvalid_nxt_s = awvalid_r;
    wvalid_nxt_s  = wvalid_r;
    bready_nxt_s  = bready_r;
    arvalid_nxt_s = arvalid_r;
    rready_nxt_s  = rready_r;
    rvalid_nxt_s  = 1'b0;
    rdata_nxt_s   = rdata_r;
    err_nxt_s     = err_r;
    case (state_r)
      IDLE: begin
        if (gnt_s) begin
          addr_nxt_s  = bus.obi_addr_i;
          be_nxt_s    = bus.obi_be_i;
          wdata_nxt_s = bus.obi_wdata_i;
          if (bus.obi_we_i) begin
            state_nxt_s   = WR;
            awvalid_nxt_s = 1'b1;
            wvalid_nxt_s  = 1'b1;
          end else begin
            state_nxt_s   = RD_ADDR;
            arvalid_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR: begin
        // AW and W complete independently, in either order or together.
        if (awvalid_r && bus.m_awready) begin
          awvalid_nxt_s = 1'b0;
        end else begin
          awvalid_nxt_s = awvalid_r;
        end
        if (wvalid_r && bus.m_wready) begin
          wvalid_nxt_s = 1'b0;
        end else begin
          wvalid_nxt_s = wvalid_r;
        end
        if (!awvalid_nxt_s && !wvalid_nxt_s) begin
          state_nxt_s  = WR_RESP;
          bready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = WR;
        end
      end
      WR_RESP: begin
        if (bus.m_bvalid && bready_r) begin
          state_nxt_s  = IDLE;
          bready_nxt_s = 1'b0;
          rvalid_nxt_s = 1'b1;
          rdata_nxt_s  = {DATA_W{1'b0}};
          err_nxt_s    = resp_is_err(bus.m_bresp);
        end else begin
          state_nxt_s = WR_RESP;
        end
      end
      RD_ADDR: begin
        if (bus.m_arready) begin
          state_nxt_s   = RD_DATA;
          arvalid_nxt_s = 1'b0;
          rready_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (bus.m_rvalid && rready_r) begin
          state_nxt_s  = IDLE;
          rready_nxt_s = 1'b0;
          rvalid_nxt_s = 1'b1;
          rdata_nxt_s  = bus.m_rdata;
          err_nxt_s    = resp_is_err(bus.m_rresp);
        end else begin
          state_nxt_s = RD_DATA;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        awvalid_nxt_s = 1'b0;
        wvalid_nxt_s  = 1'b0;
        bready_nxt_s  = 1'b0;
        arvalid_nxt_s = 1'b0;
        rready_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      addr_r    <= {ADDR_W{1'b0}};
      be_r      <= {STRB_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      addr_r    <= addr_nxt_s;
      be_r      <= be_nxt_s;
      wdata_r   <= wdata_nxt_s;
      awvalid_r <= awvalid_nxt_s;
      wvalid_r  <= wvalid_nxt_s;
      bready_r  <= bready_nxt_s;
      arvalid_r <= arvalid_nxt_s;
      rready_r  <= rready_nxt_s;
      rvalid_r  <= rvalid_nxt_s;
      rdata_r   <= rdata_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_obi_to_axil_bridge.sv
// Directed self-checking bench for obi_to_axil_bridge: inputs driven and
// outputs sampled on the falling clock edge.
module tb_obi_to_axil_bridge;
  import soc_bus_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  obi_to_axil_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  obi_to_axil_bridge #(.ADDR_W(32), .DATA_W(32), .ALIGN_ADDR(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle_inputs;
    bus.obi_req_i   = 1'b0;
    bus.obi_addr_i  = 32'h0;
    bus.obi_we_i    = 1'b0;
    bus.obi_be_i    = 4'h0;
    bus.obi_wdata_i = 32'h0;
    bus.m_awready   = 1'b0;
    bus.m_wready    = 1'b0;
    bus.m_bresp     = 2'b00;
    bus.m_bvalid    = 1'b0;
    bus.m_arready   = 1'b0;
    bus.m_rdata     = 32'h0;
    bus.m_rresp     = 2'b00;
    bus.m_rvalid    = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready,
         bus.obi_rvalid_o, bus.obi_err_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000000", {bus.m_awvalid, bus.m_wvalid,
               bus.m_bready, bus.m_arvalid, bus.m_rready, bus.obi_rvalid_o, bus.obi_err_o});
    end
    n_checks++;
    if ({bus.obi_rdata_o, bus.m_awaddr, bus.m_wdata, bus.m_wstrb} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h awaddr=%h wdata=%h wstrb=%h want all 0",
               bus.obi_rdata_o, bus.m_awaddr, bus.m_wdata, bus.m_wstrb);
    end
    rst_n = 1'b1;
  endtask

  // Single write against an always-ready slave returning bvalid one cycle after AW/W.
  task automatic run_write(input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [1:0] bresp,
                           input logic exp_err);
    logic [31:0] exp_aw;
    exp_aw = addr & 32'hFFFF_FFFC;
    @(negedge clk);
    bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b1; bus.obi_addr_i = addr;
    bus.obi_be_i = be; bus.obi_wdata_i = wdata;
    bus.m_awready = 1'b1; bus.m_wready = 1'b1;
    #1;
    n_checks++;
    if (bus.obi_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL wr_gnt: got %b want 1", bus.obi_gnt_o);
    end
    @(negedge clk);
    bus.obi_req_i = 1'b0; bus.obi_we_i = 1'b0;
    n_checks++;
    if ({bus.m_awvalid, bus.m_wvalid, bus.m_awaddr, bus.m_wdata, bus.m_wstrb} !==
        {2'b11, exp_aw, wdata, be}) begin
      n_fail++;
      $display("FAIL wr_aw_w: got v=%b%b a=%h d=%h s=%h want v=11 a=%h d=%h s=%h",
               bus.m_awvalid, bus.m_wvalid, bus.m_awaddr, bus.m_wdata, bus.m_wstrb,
               exp_aw, wdata, be);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.obi_rvalid_o} !== 4'b0010) begin
      n_fail++;
      $display("FAIL wr_bready: got aw/w/b/rv=%b%b%b%b want 0010", bus.m_awvalid,
               bus.m_wvalid, bus.m_bready, bus.obi_rvalid_o);
    end
    bus.m_bvalid = 1'b1; bus.m_bresp = bresp;
    @(negedge clk);
    bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00; bus.m_awready = 1'b0; bus.m_wready = 1'b0;
    n_checks++;
    if ({bus.obi_rvalid_o, bus.obi_err_o, bus.m_bready, bus.obi_rdata_o} !==
        {1'b1, exp_err, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL wr_resp: got rv=%b err=%b bready=%b rdata=%h want rv=1 err=%b bready=0 rdata=0",
               bus.obi_rvalid_o, bus.obi_err_o, bus.m_bready, bus.obi_rdata_o, exp_err);
    end
    @(negedge clk);
    n_checks++;
    if (bus.obi_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_pulse: rvalid got %b want 0", bus.obi_rvalid_o);
    end
  endtask

  // Single read against a slave with registered rvalid.
  task automatic run_read(input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [1:0] rresp, input logic exp_err);
    logic [31:0] exp_ar;
    exp_ar = addr & 32'hFFFF_FFFC;
    @(negedge clk);
    bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b0; bus.obi_addr_i = addr;
    bus.m_arready = 1'b1;
    #1;
    n_checks++;
    if (bus.obi_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL rd_gnt: got %b want 1", bus.obi_gnt_o);
    end
    @(negedge clk);
    bus.obi_req_i = 1'b0;
    n_checks++;
    if ({bus.m_arvalid, bus.m_araddr} !== {1'b1, exp_ar}) begin
      n_fail++;
      $display("FAIL rd_ar: got v=%b a=%h want v=1 a=%h", bus.m_arvalid, bus.m_araddr, exp_ar);
    end
    @(negedge clk);
    bus.m_arready = 1'b0;
    n_checks++;
    if ({bus.m_arvalid, bus.m_rready, bus.obi_rvalid_o} !== 3'b010) begin
      n_fail++;
      $display("FAIL rd_rready: got ar/rr/rv=%b%b%b want 010", bus.m_arvalid,
               bus.m_rready, bus.obi_rvalid_o);
    end
    bus.m_rvalid = 1'b1; bus.m_rdata = rdata; bus.m_rresp = rresp;
    @(negedge clk);
    bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0; bus.m_rresp = 2'b00;
    n_checks++;
    if ({bus.obi_rvalid_o, bus.obi_err_o, bus.m_rready, bus.obi_rdata_o} !==
        {1'b1, exp_err, 1'b0, rdata}) begin
      n_fail++;
      $display("FAIL rd_resp: got rv=%b err=%b rready=%b rdata=%h want rv=1 err=%b rready=0 rdata=%h",
               bus.obi_rvalid_o, bus.obi_err_o, bus.m_rready, bus.obi_rdata_o, exp_err, rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus.obi_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL rd_pulse: rvalid got %b want 0", bus.obi_rvalid_o);
    end
  endtask

  task automatic test_write;
    run_write(32'h0000_0104, 4'b0011, 32'hDEAD_BEEF, 2'b00, 1'b0);
  endtask

  task automatic test_read_after_write;
    // Word was 0 before; only the low half was written.
    run_read(32'h0000_0104, 32'h0000_BEEF, 2'b00, 1'b0);
  endtask

  task automatic test_aw_w_skew;
    int pulses = 0;
    int stray_bready = 0;
    @(negedge clk);
    bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b1; bus.obi_addr_i = 32'h0000_0208;
    bus.obi_be_i = 4'hF; bus.obi_wdata_i = 32'h1234_5678;
    bus.m_awready = 1'b0; bus.m_wready = 1'b1;
    @(negedge clk);
    bus.obi_req_i = 1'b0; bus.obi_addr_i = 32'hFFFF_FFFF;
    n_checks++;
    if ({bus.m_awvalid, bus.m_wvalid} !== 2'b11) begin
      n_fail++; $display("FAIL skew_start: got %b%b want 11", bus.m_awvalid, bus.m_wvalid);
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_awaddr} !== {3'b100, 32'h0000_0208}) begin
        n_fail++;
        $display("FAIL skew_hold c%0d: got aw/w/b=%b%b%b a=%h want 100 a=00000208", c,
                 bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_awaddr);
      end
    end
    bus.m_awready = 1'b1;
    @(negedge clk);
    bus.m_awready = 1'b0; bus.m_wready = 1'b0;
    n_checks++;
    if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready} !== 3'b001) begin
      n_fail++;
      $display("FAIL skew_bready: got %b%b%b want 001", bus.m_awvalid, bus.m_wvalid, bus.m_bready);
    end
    bus.m_bvalid = 1'b1;
    // Keep bvalid asserted afterwards as an unsolicited response.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.obi_rvalid_o === 1'b1) pulses++;
      if (bus.m_bready !== 1'b0) stray_bready++;
    end
    bus.m_bvalid = 1'b0;
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL skew_pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if (stray_bready != 0) begin
      n_fail++; $display("FAIL skew_bready_extra: got %0d want 0", stray_bready);
    end
  endtask

  task automatic test_error;
    run_read(32'h0000_0303, 32'hCAFE_F00D, 2'b10, 1'b1);
    run_read(32'h0000_0300, 32'h0000_1234, 2'b00, 1'b0);
    run_read(32'h0000_0300, 32'h8765_4321, 2'b11, 1'b1);
    run_read(32'h0000_0300, 32'h0BAD_F00D, 2'b01, 1'b0);
    run_write(32'h0000_0310, 4'hF, 32'h0000_0055, 2'b10, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic        we_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] addr_t [4] = '{32'h500, 32'h504, 32'h508, 32'h50C};
    logic [31:0] rd_t   [2] = '{32'hA5A5_0001, 32'h5A5A_0002};
    logic [1:0]  rr_t   [2] = '{2'b00, 2'b11};
    logic [1:0]  br_t   [2] = '{2'b00, 2'b10};
    logic [31:0] exp_d  [4] = '{32'h0, 32'hA5A5_0001, 32'h0, 32'h5A5A_0002};
    logic        exp_e  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int gi = 0, ri = 0, wr_i = 0, rd_i = 0;
    int gnt_cyc [4] = '{0, 0, 0, 0};
    logic prev_rv = 1'b0;
    bus.m_awready = 1'b1; bus.m_wready = 1'b1; bus.m_arready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus.obi_rvalid_o === 1'b1) begin
        n_checks++;
        if (ri >= 4) begin
          n_fail++; $display("FAIL b2b_extra_rvalid: cycle %0d", cyc);
        end else if ({bus.obi_rdata_o, bus.obi_err_o} !== {exp_d[ri], exp_e[ri]}) begin
          n_fail++;
          $display("FAIL b2b_resp%0d: got %h/%b want %h/%b", ri, bus.obi_rdata_o,
                   bus.obi_err_o, exp_d[ri], exp_e[ri]);
        end
        n_checks++;
        if (prev_rv) begin
          n_fail++; $display("FAIL b2b_double_rvalid: got 1 want 0 at cycle %0d", cyc);
        end
        ri++;
      end
      prev_rv = bus.obi_rvalid_o;
      n_checks++;
      if ((bus.m_awvalid || bus.m_wvalid || bus.m_bready) && (bus.m_arvalid || bus.m_rready)) begin
        n_fail++; $display("FAIL b2b_overlap: got write and read active want one at cycle %0d", cyc);
      end
      bus.m_bvalid = bus.m_bready;
      bus.m_bresp  = (bus.m_bready && wr_i < 2) ? br_t[wr_i] : 2'b00;
      if (bus.m_bready) wr_i++;
      bus.m_rvalid = bus.m_rready;
      bus.m_rdata  = (bus.m_rready && rd_i < 2) ? rd_t[rd_i] : 32'h0;
      bus.m_rresp  = (bus.m_rready && rd_i < 2) ? rr_t[rd_i] : 2'b00;
      if (bus.m_rready) rd_i++;
      if (gi < 4) begin
        bus.obi_req_i = 1'b1; bus.obi_we_i = we_t[gi]; bus.obi_addr_i = addr_t[gi];
        bus.obi_be_i = 4'hF; bus.obi_wdata_i = 32'h1000_0000 + addr_t[gi];
      end else begin
        bus.obi_req_i = 1'b0;
      end
      #1;
      if (gi < 4 && bus.obi_gnt_o === 1'b1) begin
        n_checks++;
        if (bus.m_awvalid || bus.m_wvalid || bus.m_bready || bus.m_arvalid || bus.m_rready) begin
          n_fail++; $display("FAIL b2b_gnt_busy: got grant while busy want none, cycle %0d", cyc);
        end
        gnt_cyc[gi] = cyc;
        gi++;
      end
    end
    idle_inputs();
    n_checks++;
    if (gi != 4 || ri != 4) begin
      n_fail++; $display("FAIL b2b_counts: got grants=%0d rvalids=%0d want 4/4", gi, ri);
    end
    n_checks++;
    if (gnt_cyc[1] - gnt_cyc[0] != 3 || gnt_cyc[2] - gnt_cyc[0] != 6 || gnt_cyc[3] - gnt_cyc[0] != 9) begin
      n_fail++;
      $display("FAIL b2b_spacing: got grants at %0d %0d %0d %0d want 3-cycle spacing",
               gnt_cyc[0], gnt_cyc[1], gnt_cyc[2], gnt_cyc[3]);
    end
  endtask

  task automatic test_reset_mid_read;
    int rv_seen = 0;
    @(negedge clk);
    bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b0; bus.obi_addr_i = 32'h0000_0600;
    bus.m_arready = 1'b1;
    @(negedge clk);
    bus.obi_req_i = 1'b0;
    @(negedge clk);
    bus.m_arready = 1'b0;
    n_checks++;
    if (bus.m_rready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_setup: rready got %b want 1", bus.m_rready);
    end
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid, bus.m_rready,
         bus.obi_rvalid_o, bus.obi_err_o, bus.obi_rdata_o, bus.m_araddr} !== 71'h0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got rready=%b rv=%b rdata=%h araddr=%h want all 0",
               bus.m_rready, bus.obi_rvalid_o, bus.obi_rdata_o, bus.m_araddr);
    end
    @(negedge clk);
    bus.m_rvalid = 1'b0; bus.m_rdata = 32'h0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.obi_rvalid_o !== 1'b0) rv_seen++;
    end
    n_checks++;
    if (rv_seen != 0) begin
      n_fail++; $display("FAIL rst_mid_no_resp: got %0d rvalid cycles want 0", rv_seen);
    end
    bus.obi_req_i = 1'b1; bus.obi_addr_i = 32'h0000_0700;
    #1;
    n_checks++;
    if (bus.obi_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_idle: gnt got %b want 1", bus.obi_gnt_o);
    end
    bus.obi_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_after_write();
    test_aw_w_skew();
    test_error();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
